// File: rtl/tf_table_writer.sv
// Streams packed complex twiddle factors into a twiddle RAM write port, addresses 0..tf_num-1.
// Optional build macro TF_WR_CHECKSUM_EN adds an XOR checksum of the words in the last load.
module tf_table_writer #(
    parameter int float_len        = 32,
    parameter int tf_num           = 2,
    parameter int bram_tf_addr_len = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [2*float_len-1:0]        tf_in,
    input  logic                          tf_in_valid,
    output logic                          tf_in_ready,
    output logic                          ram_we,
    output logic [bram_tf_addr_len-1:0]   ram_addr,
    output logic [2*float_len-1:0]        ram_din,
    output logic                          busy,
    output logic                          load_done,
    output logic [2*float_len-1:0]        tf_checksum
);

    localparam int W = 2 * float_len;
    localparam logic [bram_tf_addr_len-1:0] LAST_IDX = bram_tf_addr_len'(tf_num - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                        state_q, state_d;
    logic [bram_tf_addr_len-1:0]   idx_q, idx_d;
    logic                          ram_we_q, ram_we_d;
    logic [bram_tf_addr_len-1:0]   ram_addr_q, ram_addr_d;
    logic [W-1:0]                  ram_din_q, ram_din_d;
    logic                          accept_s;

    assign tf_in_ready = (state_q == ST_LOAD);
    assign busy        = (state_q == ST_LOAD) || (state_q == ST_FLUSH);
    assign load_done   = (state_q == ST_DONE);
    assign accept_s    = tf_in_valid && tf_in_ready;
    assign ram_we      = ram_we_q;
    assign ram_addr    = ram_addr_q;
    assign ram_din     = ram_din_q;

    // Next-state, index and write-port staging
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        ram_we_d   = 1'b0;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    idx_d   = '0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_LOAD: begin
                // start is deliberately ignored here so a stray pulse cannot restart the count
                if (accept_s) begin
                    ram_we_d   = 1'b1;
                    ram_addr_d = idx_q;
                    ram_din_d  = tf_in;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = ST_FLUSH;
                    end else begin
                        idx_d   = idx_q + bram_tf_addr_len'(1);
                    end
                end else begin
                    idx_d = idx_q;
                end
            end
            ST_FLUSH: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and write-port registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
        end
    end

`ifdef TF_WR_CHECKSUM_EN
    function automatic logic [W-1:0] csum_fold(input logic [W-1:0] acc, input logic [W-1:0] word);
        return acc ^ word;
    endfunction

    logic [W-1:0] csum_q, csum_d;
    logic         load_start_s;

    assign load_start_s = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign tf_checksum  = csum_q;

    // Checksum accumulator, restarted at every load
    always_comb begin
        csum_d = csum_q;
        if (load_start_s) begin
            csum_d = '0;
        end else if (accept_s) begin
            csum_d = csum_fold(csum_q, tf_in);
        end else begin
            csum_d = csum_q;
        end
    end

    // Checksum register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end
`else
    assign tf_checksum = {W{1'b0}};
`endif

endmodule

// File: tb/tb_tf_table_writer.sv
// Self-checking bench: two writer instances (tf_num=2 and tf_num=5) share one stimulus stream
// and are compared every cycle against a word-counting reference model.
module tb_tf_table_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [63:0] tf_in = 64'd0;
    logic        tf_in_valid = 1'b0;

    logic        ready2, we2, busy2, done2;
    logic [0:0]  addr2;
    logic [63:0] din2, sum2;
    logic        ready5, we5, busy5, done5;
    logic [2:0]  addr5;
    logic [63:0] din5, sum5;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tf_table_writer #(.float_len(32), .tf_num(2), .bram_tf_addr_len(1)) dut2 (
        .clk(clk), .rst(rst), .start(start), .tf_in(tf_in), .tf_in_valid(tf_in_valid),
        .tf_in_ready(ready2), .ram_we(we2), .ram_addr(addr2), .ram_din(din2),
        .busy(busy2), .load_done(done2), .tf_checksum(sum2));

    tf_table_writer #(.float_len(32), .tf_num(5), .bram_tf_addr_len(3)) dut5 (
        .clk(clk), .rst(rst), .start(start), .tf_in(tf_in), .tf_in_valid(tf_in_valid),
        .tf_in_ready(ready5), .ram_we(we5), .ram_addr(addr5), .ram_din(din5),
        .busy(busy5), .load_done(done5), .tf_checksum(sum5));

    // Reference model: per instance, whether a load is collecting words, how many it has,
    // whether the trailing write cycle is pending, and whether the table is complete.
    int          num [2] = '{2, 5};
    bit          m_load [2];
    bit          m_flush [2];
    bit          m_done [2];
    int          m_cnt [2];
    bit          m_we [2];
    int          m_addr [2];
    logic [63:0] m_din [2];
    logic [63:0] m_sum [2];

    int          wr5_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] csum_exp(input int c);
`ifdef TF_WR_CHECKSUM_EN
        return m_sum[c];
`else
        return 64'd0;
`endif
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_load[c] = 1'b0; m_flush[c] = 1'b0; m_done[c] = 1'b0; m_cnt[c] = 0;
            m_we[c] = 1'b0; m_addr[c] = 0; m_din[c] = 64'd0; m_sum[c] = 64'd0;
        end
    endtask

    task automatic model_step(input bit s, input bit v, input logic [63:0] d);
        bit acc;
        for (int c = 0; c < 2; c++) begin
            acc = m_load[c] && v;
            m_we[c] = acc;
            if (acc) begin
                m_addr[c] = m_cnt[c];
                m_din[c]  = d;
                m_sum[c]  = m_sum[c] ^ d;
            end
            if (m_load[c]) begin
                if (acc) begin
                    m_cnt[c]++;
                    if (m_cnt[c] == num[c]) begin
                        m_load[c]  = 1'b0;
                        m_flush[c] = 1'b1;
                    end
                end
            end else if (m_flush[c]) begin
                m_flush[c] = 1'b0;
                m_done[c]  = 1'b1;
            end else if (s) begin
                m_load[c] = 1'b1;
                m_done[c] = 1'b0;
                m_cnt[c]  = 0;
                m_sum[c]  = 64'd0;
            end
        end
    endtask

    task automatic compare_all();
        chk("ready2", 64'(ready2), 64'(m_load[0]));
        chk("busy2",  64'(busy2),  64'(m_load[0] | m_flush[0]));
        chk("done2",  64'(done2),  64'(m_done[0]));
        chk("we2",    64'(we2),    64'(m_we[0]));
        chk("sum2",   sum2,        csum_exp(0));
        if (m_we[0]) begin
            chk("addr2", 64'(addr2), 64'(m_addr[0]));
            chk("din2",  din2,       m_din[0]);
        end
        chk("ready5", 64'(ready5), 64'(m_load[1]));
        chk("busy5",  64'(busy5),  64'(m_load[1] | m_flush[1]));
        chk("done5",  64'(done5),  64'(m_done[1]));
        chk("we5",    64'(we5),    64'(m_we[1]));
        chk("sum5",   sum5,        csum_exp(1));
        if (m_we[1]) begin
            chk("addr5", 64'(addr5), 64'(m_addr[1]));
            chk("din5",  din5,       m_din[1]);
        end
    endtask

    // One clock: drive inputs at the falling edge, check just after the rising edge.
    task automatic cycle(input bit s, input bit v, input logic [63:0] d);
        start = s; tf_in_valid = v; tf_in = d;
        @(posedge clk);
        model_step(s, v, d);
        #1;
        compare_all();
        if (we5) wr5_q.push_back(int'(addr5));
        @(negedge clk);
    endtask

    task automatic apply_reset(input int hold);
        rst = 1'b1;
        start = 1'($urandom); tf_in_valid = 1'($urandom); tf_in = {$urandom, $urandom};
        #1;
        model_reset();
        compare_all();
        chk("rst_addr2", 64'(addr2), 64'd0);
        chk("rst_din2",  din2,       64'd0);
        chk("rst_addr5", 64'(addr5), 64'd0);
        chk("rst_din5",  din5,       64'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            start = 1'($urandom); tf_in_valid = 1'($urandom); tf_in = {$urandom, $urandom};
            @(posedge clk);
            #1;
            compare_all();
        end
        @(negedge clk);
        rst = 1'b0; start = 1'b0; tf_in_valid = 1'b0;
    endtask

    typedef struct {
        bit          s;
        bit          v;
        logic [63:0] d;
        bit          we;
        int          addr;
        bit          done;
    } vec_t;

    vec_t tbl [6];
    logic [63:0] wc, wd;
    bit          v;

    initial begin
        model_reset();
        @(negedge clk);
        apply_reset(3);

        // Valid without start must never write
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, {$urandom, $urandom});

        // Basic back-to-back load for the two-entry table
        tbl[0] = '{1'b1, 1'b0, 64'd0,                  1'b0, 0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 64'h1111_2222_3333_4444, 1'b1, 0, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 64'h5555_6666_7777_8888, 1'b1, 1, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 64'd0,                  1'b0, 0, 1'b1};
        tbl[4] = '{1'b0, 1'b1, 64'hDEAD_BEEF_0000_0001, 1'b0, 0, 1'b1};
        tbl[5] = '{1'b0, 1'b0, 64'd0,                  1'b0, 0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            cycle(tbl[i].s, tbl[i].v, tbl[i].d);
            chk("tbl_we", 64'(we2), 64'(tbl[i].we));
            if (tbl[i].we) chk("tbl_addr", 64'(addr2), 64'(tbl[i].addr));
            chk("tbl_done", 64'(done2), 64'(tbl[i].done));
        end
`ifdef TF_WR_CHECKSUM_EN
        chk("basic_sum", sum2, 64'h4444_4444_4444_CCCC);
`else
        chk("basic_sum", sum2, 64'd0);
`endif

        // Reload the two-entry table without reset
        wc = {$urandom, $urandom};
        wd = {$urandom, $urandom};
        cycle(1'b1, 1'b0, 64'd0);
        chk("reload_done_drop", 64'(done2), 64'd0);
        cycle(1'b0, 1'b1, wc);
        chk("reload_addr0", 64'(addr2), 64'd0);
        cycle(1'b0, 1'b1, wd);
        cycle(1'b0, 1'b0, 64'd0);
        chk("reload_done", 64'(done2), 64'd1);
`ifdef TF_WR_CHECKSUM_EN
        chk("reload_sum", sum2, wc ^ wd);
`else
        chk("reload_sum", sum2, 64'd0);
`endif

        // Gapped stream into the five-entry table, with an ignored start mid-load
        apply_reset(1);
        wr5_q.delete();
        cycle(1'b1, 1'b0, 64'd0);
        for (int i = 0; i < 16; i++) begin
            v = (i % 2 == 0);
            cycle((i == 5), v, {$urandom, $urandom});
        end
        chk("gap_writes", 64'(wr5_q.size()), 64'd5);
        for (int i = 0; i < wr5_q.size(); i++) chk("gap_addr", 64'(wr5_q[i]), 64'(i));
        chk("gap_done", 64'(done5), 64'd1);

        // Reset after one accepted word, then a full fresh load
        apply_reset(0);
        cycle(1'b1, 1'b0, 64'd0);
        cycle(1'b0, 1'b1, {$urandom, $urandom});
        chk("mid_we", 64'(we5), 64'd1);
        apply_reset(1);
        wr5_q.delete();
        cycle(1'b1, 1'b0, 64'd0);
        for (int i = 0; i < 7; i++) cycle(1'b0, (i < 5), {$urandom, $urandom});
        chk("mid_writes", 64'(wr5_q.size()), 64'd5);
        for (int i = 0; i < wr5_q.size(); i++) chk("mid_addr", 64'(wr5_q[i]), 64'(i));
        chk("mid_done", 64'(done5), 64'd1);

        // Random traffic with occasional resets
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 199) == 0) apply_reset(int'($urandom_range(0, 2)));
            cycle(($urandom_range(0, 11) == 0), 1'($urandom), {$urandom, $urandom});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
